// File: rtl/fpu_normalize.sv
// Post-add normalize / round-to-nearest-even / pack stage for single precision.
// Iterative renormalization, one bit per cycle, with valid/ready on both sides.
module fpu_normalize (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exponent,
    input  logic [24:0] in_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow
);

    localparam int unsigned MW = 25;
    localparam int unsigned EW = 9;
    localparam int unsigned RW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [MW-1:0]   m, m_nxt;
    logic [EW-1:0]   e, e_nxt;
    logic            g, g_nxt;
    logic            s, s_nxt;
    logic [RW-1:0]   res_nxt;
    logic            ovf_nxt, unf_nxt;
    logic [MW-1:0]   m_inc, m_adj;
    logic [EW-1:0]   e_adj;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) state_nxt = NORM;
            end
            NORM: begin
                if (m == '0)                      state_nxt = DONE;
                else if (m[24] || m[23])          state_nxt = ROUND;
                else if (e <= EW'(1))             state_nxt = DONE;
            end
            ROUND: state_nxt = DONE;
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and result next-values
    always_comb begin
        m_nxt   = m;
        e_nxt   = e;
        g_nxt   = g;
        s_nxt   = s;
        res_nxt = out_result;
        ovf_nxt = out_overflow;
        unf_nxt = out_underflow;

        // Round on the guard bit; a tie (lsb 0) truncates to even.
        m_inc = m + MW'(g & m[0]);
        if (m_inc[24]) begin
            m_adj = {1'b0, m_inc[24:1]};
            e_adj = EW'(e + EW'(1));
        end else begin
            m_adj = m_inc;
            e_adj = e;
        end

        case (state)
            IDLE: begin
                if (in_valid) begin
                    m_nxt = in_mantissa;
                    e_nxt = {1'b0, in_exponent};
                    s_nxt = in_sign;
                    g_nxt = 1'b0;
                end
            end
            NORM: begin
                if (m == '0) begin
                    res_nxt = {s, 31'h0};
                    ovf_nxt = 1'b0;
                    unf_nxt = 1'b0;
                end else if (m[24]) begin
                    g_nxt = m[0];
                    m_nxt = {1'b0, m[24:1]};
                    e_nxt = EW'(e + EW'(1));
                end else if (!m[23]) begin
                    if (e <= EW'(1)) begin
                        res_nxt = {s, 31'h0};
                        ovf_nxt = 1'b0;
                        unf_nxt = 1'b1;
                    end else begin
                        m_nxt = {m[23:0], 1'b0};
                        e_nxt = EW'(e - EW'(1));
                    end
                end
            end
            ROUND: begin
                m_nxt   = m_adj;
                e_nxt   = e_adj;
                g_nxt   = 1'b0;
                unf_nxt = 1'b0;
                if (e_adj >= EW'(255)) begin
                    res_nxt = {s, 8'hFF, 23'h0};
                    ovf_nxt = 1'b1;
                end else begin
                    res_nxt = {s, e_adj[7:0], m_adj[22:0]};
                    ovf_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Working and output registers; handshake flags track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m             <= '0;
            e             <= '0;
            g             <= 1'b0;
            s             <= 1'b0;
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
        end else begin
            m             <= m_nxt;
            e             <= e_nxt;
            g             <= g_nxt;
            s             <= s_nxt;
            in_ready      <= (state_nxt == IDLE);
            out_valid     <= (state_nxt == DONE);
            out_result    <= res_nxt;
            out_overflow  <= ovf_nxt;
            out_underflow <= unf_nxt;
        end
    end

endmodule
